pc_redirect_ctrl: RTL and testbench

//  Sequences every non-sequential update of the fetch PC register.
//  - Arbitrates three redirect sources: CSR trap/return, EX branch mispredict and ID early jump.
//  - Holds a redirect that arrives while fetch is MMU-stalled until fetch can take it.
//  - Runs the FENCE drain sequence: hold, wait for an empty pipeline, settle, then refetch fence_pc+4.
//  - Drives the PC register's select/target/hold inputs and the IF/ID flush lines.

---
 rtl/pc_redirect_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC redirect controller: arbitrates trap/mispredict/jump/fence redirects,
// holds redirects across MMU stalls. Define PC_REDIRECT_STATS_EN for per-cause counters.
module pc_redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter int unsigned FENCE_SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            br_mispredict,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            fence_req,
  input  logic [XLEN-1:0] fence_pc,
  input  logic            pipe_empty,
  input  logic            stall_early,
  input  logic            stall_mmu,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      redirect_cause,
  output logic            pc_hold,
  output logic            flush_if,
  output logic            flush_id,
  output logic            fence_busy
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]     stat_trap,
  output logic [31:0]     stat_mispredict,
  output logic [31:0]     stat_jump,
  output logic [31:0]     stat_fence
`endif
);

  localparam int unsigned CntW = (FENCE_SETTLE > 1) ? $clog2(FENCE_SETTLE) : 1;

  typedef enum logic [1:0] {StIdle, StPend, StFwait, StFsettle} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [1:0]      pend_cause_q, pend_cause_d;
  logic [XLEN-1:0] fence_tgt_q, fence_tgt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            hi_req;
  logic [XLEN-1:0] hi_pc;
  logic [1:0]      hi_cause;
  logic            take;
  logic [XLEN-1:0] take_pc;
  logic [1:0]      take_cause;
  logic            fence_fire;

  assign hi_req   = trap_valid | br_mispredict;
  assign hi_pc    = trap_valid ? trap_target : br_target;
  assign hi_cause = trap_valid ? 2'd1 : 2'd2;

  always_comb begin
    state_d        = state_q;
    pend_pc_d      = pend_pc_q;
    pend_cause_d   = pend_cause_q;
    fence_tgt_d    = fence_tgt_q;
    cnt_d          = cnt_q;
    take           = 1'b0;
    take_pc        = '0;
    take_cause     = 2'd0;
    fence_fire     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = RESET_VECTOR;
    redirect_cause = 2'd0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hi_req) begin
          take = 1'b1; take_pc = hi_pc; take_cause = hi_cause;
        end else if (jmp_valid) begin
          take = 1'b1; take_pc = jmp_target; take_cause = 2'd3;
        end else if (fence_req) begin
          flush_if    = 1'b1;
          fence_tgt_d = fence_pc + XLEN'(4);
          state_d     = StFwait;
        end
      end
      StPend: begin
        // An early jump here is on the wrong path behind the pending redirect.
        if (hi_req) begin
          take = 1'b1; take_pc = hi_pc; take_cause = hi_cause;
        end else if (!stall_mmu) begin
          redirect_valid = 1'b1;
          redirect_pc    = pend_pc_q;
          redirect_cause = pend_cause_q;
          state_d        = StIdle;
        end
      end
      StFwait: begin
        if (hi_req) begin
          take = 1'b1; take_pc = hi_pc; take_cause = hi_cause;
        end else if (pipe_empty) begin
          cnt_d   = CntW'(FENCE_SETTLE - 1);
          state_d = StFsettle;
        end
      end
      StFsettle: begin
        if (hi_req) begin
          take = 1'b1; take_pc = hi_pc; take_cause = hi_cause;
        end else if (cnt_q == '0) begin
          if (!stall_mmu) begin
            fence_fire     = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = fence_tgt_q;
            redirect_cause = 2'd3;
            state_d        = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      flush_if = 1'b1;
      flush_id = (take_cause != 2'd3);
      if (!stall_mmu) begin
        redirect_valid = 1'b1;
        redirect_pc    = take_pc;
        redirect_cause = take_cause;
        state_d        = StIdle;
      end else begin
        pend_pc_d    = take_pc;
        pend_cause_d = take_cause;
        state_d      = StPend;
      end
    end

    fence_busy = ((state_q == StFwait) || (state_q == StFsettle)) && !fence_fire;
    pc_hold    = (stall_early | stall_mmu | fence_busy | (state_q == StPend)) & ~redirect_valid;

    if (rst) begin
      redirect_valid = 1'b0;
      redirect_pc    = RESET_VECTOR;
      redirect_cause = 2'd0;
      flush_if       = 1'b0;
      flush_id       = 1'b0;
      fence_busy     = 1'b0;
      pc_hold        = 1'b0;
      fence_fire     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pend_pc_q    <= '0;
      pend_cause_q <= 2'd0;
      fence_tgt_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_pc_q    <= pend_pc_d;
      pend_cause_q <= pend_cause_d;
      fence_tgt_q  <= fence_tgt_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_trap       <= '0;
      stat_mispredict <= '0;
      stat_jump       <= '0;
      stat_fence      <= '0;
    end else if (redirect_valid) begin
      if (fence_fire) begin
        stat_fence <= stat_fence + 32'd1;
      end else begin
        case (redirect_cause)
          2'd1:    stat_trap       <= stat_trap + 32'd1;
          2'd2:    stat_mispredict <= stat_mispredict + 32'd1;
          2'd3:    stat_jump       <= stat_jump + 32'd1;
          default: ;
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: expected redirects are queued when driven
// and compared by a monitor whenever the DUT issues one.
module tb_pc_redirect_ctrl;
  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV  = 32'h8000_0000;

  logic            clk, rst;
  logic            trap_valid, br_mispredict, jmp_valid, fence_req;
  logic [XLEN-1:0] trap_target, br_target, jmp_target, fence_pc;
  logic            pipe_empty, stall_early, stall_mmu;
  logic            redirect_valid, pc_hold, flush_if, flush_id, fence_busy;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0]      redirect_cause;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [XLEN+1:0] exp_q[$];

  pc_redirect_ctrl #(.XLEN(XLEN), .RESET_VECTOR(RV), .FENCE_SETTLE(4)) dut (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .br_mispredict(br_mispredict), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .fence_req(fence_req), .fence_pc(fence_pc),
    .pipe_empty(pipe_empty), .stall_early(stall_early), .stall_mmu(stall_mmu),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_cause(redirect_cause), .pc_hold(pc_hold),
    .flush_if(flush_if), .flush_id(flush_id), .fence_busy(fence_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every issued redirect must match the oldest queued expectation.
  always @(negedge clk) begin
    if (redirect_valid === 1'b1) begin
      logic [XLEN+1:0] e;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL redirect_unexpected: got pc=%h cause=%0d, required no redirect",
                 redirect_pc, redirect_cause);
      end else begin
        e = exp_q.pop_front();
        if ({redirect_cause, redirect_pc} !== e)
          $display("FAIL redirect_match: got pc=%h cause=%0d, required pc=%h cause=%0d",
                   redirect_pc, redirect_cause, e[XLEN-1:0], e[XLEN+1:XLEN]);
        else pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    trap_valid = 0; br_mispredict = 0; jmp_valid = 0; fence_req = 0;
    trap_target = '0; br_target = '0; jmp_target = '0; fence_pc = '0;
    pipe_empty = 0; stall_early = 0; stall_mmu = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); stall_early = 1;
    tick(); tick(); #1;
    total_cnt++;
    if ({redirect_valid, pc_hold, flush_if, flush_id, fence_busy} !== 5'b0)
      $display("FAIL reset_bits: got %b, required 00000",
               {redirect_valid, pc_hold, flush_if, flush_id, fence_busy});
    else pass_cnt++;
    total_cnt++;
    if (redirect_pc !== RV) $display("FAIL reset_pc: got %h, required %h", redirect_pc, RV);
    else pass_cnt++;
    total_cnt++;
    if (redirect_cause !== 2'd0) $display("FAIL reset_cause: got %0d, required 0", redirect_cause);
    else pass_cnt++;
    tick(); rst = 0; stall_early = 0; #1;
    total_cnt++;
    if ({redirect_valid, pc_hold, flush_if, flush_id, fence_busy} !== 5'b0)
      $display("FAIL idle_bits: got %b, required 00000",
               {redirect_valid, pc_hold, flush_if, flush_id, fence_busy});
    else pass_cnt++;
  endtask

  task automatic test_mispredict();
    tick(); br_mispredict = 1; br_target = 32'h8000_0100; stall_early = 1;
    exp_q.push_back({2'd2, 32'h8000_0100}); #1;
    total_cnt++;
    if ({flush_if, flush_id, pc_hold} !== 3'b110)
      $display("FAIL mispredict_flush: got if/id/hold=%b, required 110", {flush_if, flush_id, pc_hold});
    else pass_cnt++;
    tick(); clear_inputs(); stall_early = 1; #1;
    total_cnt++;
    if (pc_hold !== 1'b1) $display("FAIL stall_early_hold: got %b, required 1", pc_hold);
    else pass_cnt++;
    tick(); clear_inputs();
  endtask

  task automatic test_priority();
    tick(); trap_valid = 1; trap_target = 32'h8000_0040;
    br_mispredict = 1; br_target = 32'h8000_0900; jmp_valid = 1; jmp_target = 32'h8000_0a00;
    exp_q.push_back({2'd1, 32'h8000_0040}); #1;
    total_cnt++;
    if (flush_id !== 1'b1) $display("FAIL priority_flush_id: got %b, required 1", flush_id);
    else pass_cnt++;
    tick(); clear_inputs(); tick();
  endtask

  task automatic test_jump();
    tick(); jmp_valid = 1; jmp_target = 32'h8000_0080;
    exp_q.push_back({2'd3, 32'h8000_0080}); #1;
    total_cnt++;
    if ({flush_if, flush_id} !== 2'b10)
      $display("FAIL jump_flush: got if/id=%b, required 10", {flush_if, flush_id});
    else pass_cnt++;
    tick(); clear_inputs();
  endtask

  task automatic test_pend();
    tick(); jmp_valid = 1; jmp_target = 32'h8000_0200; stall_mmu = 1; #1;
    total_cnt++;
    if ({redirect_valid, flush_if, flush_id} !== 3'b010)
      $display("FAIL pend_t0: got rv/if/id=%b, required 010", {redirect_valid, flush_if, flush_id});
    else pass_cnt++;
    tick(); jmp_valid = 0; br_mispredict = 1; br_target = 32'h8000_0300; #1;
    total_cnt++;
    if ({redirect_valid, flush_if, flush_id, pc_hold} !== 4'b0111)
      $display("FAIL pend_t1: got rv/if/id/hold=%b, required 0111",
               {redirect_valid, flush_if, flush_id, pc_hold});
    else pass_cnt++;
    tick(); br_mispredict = 0; jmp_valid = 1; jmp_target = 32'h8000_0b00; #1;
    total_cnt++;
    if ({redirect_valid, flush_if, pc_hold} !== 3'b001)
      $display("FAIL pend_t2: got rv/if/hold=%b, required 001", {redirect_valid, flush_if, pc_hold});
    else pass_cnt++;
    tick(); clear_inputs(); exp_q.push_back({2'd2, 32'h8000_0300}); #1;
    total_cnt++;
    if ({redirect_valid, pc_hold} !== 2'b10)
      $display("FAIL pend_release: got rv/hold=%b, required 10", {redirect_valid, pc_hold});
    else pass_cnt++;
    tick(); tick();
  endtask

  task automatic test_fence(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                            input int wait_cycles);
    tick(); fence_req = 1; fence_pc = pc; #1;
    total_cnt++;
    if ({flush_if, fence_busy, redirect_valid} !== 3'b100)
      $display("FAIL fence_req: got if/busy/rv=%b, required 100", {flush_if, fence_busy, redirect_valid});
    else pass_cnt++;
    for (int i = 1; i <= wait_cycles; i++) begin
      tick(); fence_req = 0; fence_pc = '0; pipe_empty = (i == wait_cycles); #1;
      total_cnt++;
      if ({fence_busy, pc_hold} !== 2'b11)
        $display("FAIL fence_wait%0d: got busy/hold=%b, required 11", i, {fence_busy, pc_hold});
      else pass_cnt++;
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) exp_q.push_back({2'd3, tgt});
      #1;
      total_cnt++;
      if ({redirect_valid, fence_busy, pc_hold} !== ((k == 4) ? 3'b100 : 3'b011))
        $display("FAIL fence_settle%0d: got rv/busy/hold=%b, required %b", k,
                 {redirect_valid, fence_busy, pc_hold}, (k == 4) ? 3'b100 : 3'b011);
      else pass_cnt++;
    end
    tick(); clear_inputs(); #1;
    total_cnt++;
    if (fence_busy !== 1'b0) $display("FAIL fence_done: got busy=%b, required 0", fence_busy);
    else pass_cnt++;
  endtask

  task automatic test_fence_abort();
    tick(); fence_req = 1; fence_pc = 32'h8000_0020;
    tick(); clear_inputs();
    tick(); trap_valid = 1; trap_target = 32'h8000_0500;
    exp_q.push_back({2'd1, 32'h8000_0500}); #1;
    total_cnt++;
    if ({fence_busy, flush_id} !== 2'b11)
      $display("FAIL abort_cycle: got busy/id=%b, required 11", {fence_busy, flush_id});
    else pass_cnt++;
    tick(); clear_inputs(); pipe_empty = 1; #1;
    total_cnt++;
    if (fence_busy !== 1'b0) $display("FAIL abort_busy: got %b, required 0", fence_busy);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    tick(); br_mispredict = 1; br_target = 32'h8000_0600;
    exp_q.push_back({2'd2, 32'h8000_0600});
    tick(); br_mispredict = 0; trap_valid = 1; trap_target = 32'h8000_0700;
    exp_q.push_back({2'd1, 32'h8000_0700});
    tick(); clear_inputs(); tick();
  endtask

  task automatic test_reset_pend();
    tick(); jmp_valid = 1; jmp_target = 32'h8000_0800; stall_mmu = 1;
    tick(); jmp_valid = 0; rst = 1; #1;
    total_cnt++;
    if ({redirect_valid, pc_hold, flush_if, flush_id, fence_busy} !== 5'b0)
      $display("FAIL rst_pend_during: got %b, required 00000",
               {redirect_valid, pc_hold, flush_if, flush_id, fence_busy});
    else pass_cnt++;
    tick(); rst = 0; stall_mmu = 0; #1;
    total_cnt++;
    if ({redirect_valid, pc_hold, flush_if, flush_id, fence_busy} !== 5'b0)
      $display("FAIL rst_pend_after: got %b, required 00000",
               {redirect_valid, pc_hold, flush_if, flush_id, fence_busy});
    else pass_cnt++;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_priority();
    test_jump();
    test_pend();
    test_fence(32'h8000_0010, 32'h8000_0014, 5);
    test_fence(32'hFFFF_FFFC, 32'h0000_0000, 1);
    test_fence_abort();
    test_back_to_back();
    test_reset_pend();
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL redirects_missing: got %0d outstanding, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
